// File: rtl/stream_extreme_reduce_ctrl.sv
// Reduces a 4-lane stream to its max (or min) value and the index of its first occurrence.
// Latency: last beat at t -> done/result at t+2. Backpressure: in_valid low in RUN stalls indefinitely.
module stream_extreme_reduce_ctrl #(
  parameter int BW_DATA  = 8,
  parameter int UNSIGNED = 1,
  parameter int FIND_MIN = 0,
  parameter int BW_COUNT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BW_COUNT-1:0]   cfg_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*BW_DATA-1:0]  in_data,
  output logic                  busy,
  output logic                  done,
  output logic                  result_valid,
  output logic [BW_DATA-1:0]    result_value,
  output logic [BW_COUNT-1:0]   result_index
);

  localparam int BW_WIDE = BW_COUNT + 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic                vld;
    logic [BW_DATA-1:0]  val;
    logic [BW_COUNT-1:0] idx;
  } cand_t;

  // Signed compare is done as unsigned after flipping the sign bit.
  function automatic logic better(input logic [BW_DATA-1:0] a, input logic [BW_DATA-1:0] b);
    logic [BW_DATA-1:0] ka;
    logic [BW_DATA-1:0] kb;
    ka = a;
    kb = b;
    if (UNSIGNED == 0) begin
      ka[BW_DATA-1] = ~a[BW_DATA-1];
      kb[BW_DATA-1] = ~b[BW_DATA-1];
    end
    return (FIND_MIN != 0) ? (ka < kb) : (ka > kb);
  endfunction

  // a is always the earlier candidate, so b wins only when strictly better.
  function automatic cand_t pick(input cand_t a, input cand_t b);
    return (b.vld && (!a.vld || better(b.val, a.val))) ? b : a;
  endfunction

  state_t              state;
  logic [BW_COUNT-1:0] len_q;
  logic [BW_COUNT-1:0] beat;
  cand_t               stage;
  cand_t               acc;

  logic [BW_WIDE-1:0]  base_w;
  logic [BW_WIDE-1:0]  len_w;
  logic [BW_WIDE-1:0]  lane_w [4];
  cand_t               lane [4];
  cand_t               tree_win;
  cand_t               merged;
  logic                last_beat;
  logic                fire;

  assign base_w    = {beat, 2'b00};
  assign len_w     = {2'b00, len_q};
  assign last_beat = (base_w + BW_WIDE'(4)) >= len_w;
  assign fire      = in_valid & in_ready;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_w[i]    = base_w + BW_WIDE'(i);
      lane[i].vld  = lane_w[i] < len_w;
      lane[i].val  = in_data[BW_DATA*i +: BW_DATA];
      lane[i].idx  = lane_w[i][BW_COUNT-1:0];
    end
    tree_win = pick(pick(lane[0], lane[1]), pick(lane[2], lane[3]));
    merged   = pick(acc, stage);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      len_q        <= '0;
      beat         <= '0;
      stage        <= '0;
      acc          <= '0;
      in_ready     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
      result_value <= '0;
      result_index <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q        <= cfg_len;
            beat         <= '0;
            acc          <= '0;
            stage        <= '0;
            result_valid <= 1'b0;
            result_value <= '0;
            result_index <= '0;
            busy         <= 1'b1;
            if (cfg_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= RUN;
              in_ready <= 1'b1;
            end
          end
        end
        RUN: begin
          acc <= merged;
          if (fire) begin
            stage <= tree_win;
            beat  <= beat + 1'b1;
            if (last_beat) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end else begin
            stage.vld <= 1'b0;
          end
        end
        DRAIN: begin
          // Result is taken from the merge itself so it is visible in the DONE cycle.
          acc          <= merged;
          stage.vld    <= 1'b0;
          result_valid <= merged.vld;
          result_value <= merged.val;
          result_index <= merged.idx;
          state        <= DONE;
          done         <= 1'b1;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_extreme_reduce_ctrl.sv
// Directed bench: unsigned-max, signed-max and signed-min instances share one stimulus stream.
module tb_stream_extreme_reduce_ctrl;
  localparam int BW = 8;
  localparam int BC = 16;

  logic          clk = 1'b0;
  logic          rst, start, in_valid;
  logic [BC-1:0] cfg_len;
  logic [4*BW-1:0] in_data;

  logic          rdy_u, busy_u, done_u, rv_u;
  logic [BW-1:0] val_u;
  logic [BC-1:0] idx_u;
  logic          rdy_s, busy_s, done_s, rv_s;
  logic [BW-1:0] val_s;
  logic [BC-1:0] idx_s;
  logic          rdy_m, busy_m, done_m, rv_m;
  logic [BW-1:0] val_m;
  logic [BC-1:0] idx_m;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stream_extreme_reduce_ctrl #(.BW_DATA(BW), .UNSIGNED(1), .FIND_MIN(0), .BW_COUNT(BC)) dut_u (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .in_valid(in_valid),
    .in_ready(rdy_u), .in_data(in_data), .busy(busy_u), .done(done_u),
    .result_valid(rv_u), .result_value(val_u), .result_index(idx_u));

  stream_extreme_reduce_ctrl #(.BW_DATA(BW), .UNSIGNED(0), .FIND_MIN(0), .BW_COUNT(BC)) dut_s (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .in_valid(in_valid),
    .in_ready(rdy_s), .in_data(in_data), .busy(busy_s), .done(done_s),
    .result_valid(rv_s), .result_value(val_s), .result_index(idx_s));

  stream_extreme_reduce_ctrl #(.BW_DATA(BW), .UNSIGNED(0), .FIND_MIN(1), .BW_COUNT(BC)) dut_m (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .in_valid(in_valid),
    .in_ready(rdy_m), .in_data(in_data), .busy(busy_m), .done(done_m),
    .result_valid(rv_m), .result_value(val_m), .result_index(idx_m));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4*BW-1:0] pack4(input logic [7:0] l0, input logic [7:0] l1,
                                            input logic [7:0] l2, input logic [7:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // Checks the DONE cycle of all three instances against hand-computed winners.
  task automatic chk_done(input string tag,
                          input logic [7:0] vu, input logic [15:0] iu,
                          input logic [7:0] vs, input logic [15:0] is,
                          input logic [7:0] vm, input logic [15:0] im);
    chk({tag, "_done"}, {31'd0, done_u}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy_u}, 32'd1);
    chk({tag, "_rv"},   {31'd0, rv_u},   32'd1);
    chk({tag, "_val_u"}, {24'd0, val_u}, {24'd0, vu});
    chk({tag, "_idx_u"}, {16'd0, idx_u}, {16'd0, iu});
    chk({tag, "_val_s"}, {24'd0, val_s}, {24'd0, vs});
    chk({tag, "_idx_s"}, {16'd0, idx_s}, {16'd0, is});
    chk({tag, "_val_m"}, {24'd0, val_m}, {24'd0, vm});
    chk({tag, "_idx_m"}, {16'd0, idx_m}, {16'd0, im});
  endtask

  initial begin
    // Reset, with start raised alongside it: reset must win.
    rst = 1'b1; start = 1'b1; cfg_len = 16'd4; in_valid = 1'b0; in_data = '0;
    step(); step();
    chk("rst_rdy",  {31'd0, rdy_u},  32'd0);
    chk("rst_busy", {31'd0, busy_u}, 32'd0);
    chk("rst_done", {31'd0, done_u}, 32'd0);
    chk("rst_rv",   {31'd0, rv_u},   32'd0);
    chk("rst_val",  {24'd0, val_u},  32'd0);
    chk("rst_idx",  {16'd0, idx_u},  32'd0);
    rst = 1'b0; start = 1'b0;
    step();
    chk("idle_busy", {31'd0, busy_u}, 32'd0);

    // len=4 single beat {3,200,17,200}: ties resolve to the lower lane.
    start = 1'b1; cfg_len = 16'd4;
    step();
    start = 1'b0;
    chk("t1_busy", {31'd0, busy_u}, 32'd1);
    chk("t1_rdy",  {31'd0, rdy_u},  32'd1);
    in_valid = 1'b1; in_data = pack4(8'd3, 8'd200, 8'd17, 8'd200);
    step();
    in_valid = 1'b0;
    chk("t1_drain_rdy",  {31'd0, rdy_u},  32'd0);
    chk("t1_drain_done", {31'd0, done_u}, 32'd0);
    step();
    chk_done("t1", 8'd200, 16'd1, 8'd17, 16'd2, 8'd200, 16'd1);
    step();
    chk("t1_idle_done", {31'd0, done_u}, 32'd0);
    chk("t1_idle_busy", {31'd0, busy_u}, 32'd0);
    chk("t1_hold_val",  {24'd0, val_u},  32'd200);

    // len=6: lanes 6 and 7 of the second beat hold 255 but must be masked.
    start = 1'b1; cfg_len = 16'd6;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = pack4(8'd1, 8'd2, 8'd3, 8'd4);
    step();
    chk("t2_rdy_mid", {31'd0, rdy_u}, 32'd1);
    in_data = pack4(8'd9, 8'd250, 8'd255, 8'd255);
    step();
    in_valid = 1'b0;
    chk("t2_drain_rdy", {31'd0, rdy_u}, 32'd0);
    step();
    chk_done("t2", 8'd250, 16'd5, 8'd9, 16'd4, 8'd250, 16'd5);
    step();

    // len=4 {0x80,0x7F,0xFF,0x00}: signedness changes every winner.
    start = 1'b1; cfg_len = 16'd4;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = pack4(8'h80, 8'h7F, 8'hFF, 8'h00);
    step();
    in_valid = 1'b0;
    step();
    chk_done("t3", 8'hFF, 16'd2, 8'h7F, 16'd1, 8'h80, 16'd0);
    step();

    // len=8 with in_valid 1,0,0,1; a start during RUN must be ignored.
    start = 1'b1; cfg_len = 16'd8;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = pack4(8'd10, 8'd20, 8'd30, 8'd40);
    step();
    in_valid = 1'b0; start = 1'b1; cfg_len = 16'd2;
    step();
    start = 1'b0;
    chk("t4_stall1_rdy",  {31'd0, rdy_u},  32'd1);
    chk("t4_stall1_busy", {31'd0, busy_u}, 32'd1);
    step();
    chk("t4_stall2_rdy",  {31'd0, rdy_u},  32'd1);
    chk("t4_stall2_busy", {31'd0, busy_u}, 32'd1);
    in_valid = 1'b1; in_data = pack4(8'd1, 8'd2, 8'd42, 8'd3);
    step();
    in_valid = 1'b0;
    chk("t4_drain_rdy",  {31'd0, rdy_u},  32'd0);
    chk("t4_drain_busy", {31'd0, busy_u}, 32'd1);
    step();
    chk_done("t4", 8'd42, 16'd6, 8'd42, 16'd6, 8'd1, 16'd4);
    step();

    // len=0 goes straight to DONE with an empty result; start in DONE is ignored.
    start = 1'b1; cfg_len = 16'd0;
    step();
    cfg_len = 16'd4;
    chk("t5_done", {31'd0, done_u}, 32'd1);
    chk("t5_busy", {31'd0, busy_u}, 32'd1);
    chk("t5_rdy",  {31'd0, rdy_u},  32'd0);
    chk("t5_rv",   {31'd0, rv_u},   32'd0);
    chk("t5_val",  {24'd0, val_u},  32'd0);
    chk("t5_idx",  {16'd0, idx_u},  32'd0);
    step();
    start = 1'b0;
    chk("t5_idle_done", {31'd0, done_u}, 32'd0);
    chk("t5_idle_busy", {31'd0, busy_u}, 32'd0);
    chk("t5_idle_rdy",  {31'd0, rdy_u},  32'd0);
    step();
    chk("t5_ignored_busy", {31'd0, busy_u}, 32'd0);

    // Reset after 1 of 3 beats discards the partial reduction.
    start = 1'b1; cfg_len = 16'd12;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = pack4(8'd99, 8'd98, 8'd97, 8'd96);
    step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_rdy",  {31'd0, rdy_u},  32'd0);
    chk("t6_rst_busy", {31'd0, busy_u}, 32'd0);
    chk("t6_rst_done", {31'd0, done_u}, 32'd0);
    step();
    chk("t6_no_done", {31'd0, done_u}, 32'd0);
    chk("t6_no_busy", {31'd0, busy_u}, 32'd0);
    start = 1'b1; cfg_len = 16'd4;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = pack4(8'd5, 8'd5, 8'd5, 8'd5);
    step();
    in_valid = 1'b0;
    step();
    chk_done("t6", 8'd5, 16'd0, 8'd5, 16'd0, 8'd5, 16'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
